mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory access stage that sits directly downstream of the ALU in the nonpipelined LEGv8 datapath.
- Takes the ALU result as the effective address for LDUR/STUR-family instructions and runs a req/ack transaction on a 64-bit data bus.
- Performs byte-lane alignment plus load sign/zero extension, and reports faults.
- Drives a stall (busy) to the control unit while a transaction is outstanding.

Parameters:
- WORD, 64 (from constants.vh): datapath width.
- TIMEOUT, 255: max cycles to wait for bus_ack before declaring a timeout fault; valid range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  memory op request from control; sampled only in IDLE.
- mem_read  in  1  load operation.
- mem_write  in  1  store operation.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- sign_ext  in  1  sign-extend load result (LDURSW etc.); ignored for stores and dword.
- address  in  WORD  effective address (ALU result).
- store_data  in  WORD  Rt value; the low size bytes are stored.
- busy  out  1  stall to control; high while state is REQ.
- done  out  1  one-cycle pulse: operation finished.
- load_data  out  WORD  extended load result; holds its value until the next successful load.
- fault  out  1  asserted with done when the op failed.
- fault_code  out  3  0 none, 1 misaligned, 2 bus error, 3 timeout, 4 illegal (read and write both set).
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  WORD  address with [2:0] forced to 0.
- bus_wdata  out  WORD  store data shifted into lane position.
- bus_be  out  8  byte enables.
- bus_ack  in  1  transaction complete.
- bus_rdata  in  WORD  read data, valid with bus_ack.
- bus_err  in  1  error response, valid with bus_ack.

Behaviour:
- Reset: state is IDLE. All outputs are 0, including load_data and bus_req. Reset takes effect asynchronously, so an outstanding bus_req drops immediately and the transaction is abandoned.
- States and transitions:
  - IDLE:
    - start with neither read nor write: ignored; stay in IDLE.
    - start with both read and write: go to DONE, fault_code 4, no bus activity.
    - start with address not a multiple of the access size (byte: any address; half: [0]=0; word: [1:0]=0; dword: [2:0]=0): go to DONE, fault_code 1, no bus activity.
    - otherwise: register bus_addr, bus_we, bus_be and bus_wdata; clear the timeout counter; go to REQ.
  - REQ: bus_req=1 and busy=1; the counter increments each cycle.
    - bus_ack=1 and bus_err=0: on a read, register the extended data into load_data. Go to DONE, fault_code 0.
    - bus_ack=1 and bus_err=1: go to DONE, fault_code 2; load_data unchanged.
    - no ack and counter reaches TIMEOUT: go to DONE, fault_code 3; bus_req drops.
  - DONE: done=1 for exactly one cycle. fault = (fault_code != 0). Always return to IDLE; start is ignored in DONE.
- bus_ack outside REQ is ignored.
- Inputs are sampled only on the accept edge, so later input changes do not affect the op in flight.
- fault_code holds its value until the next accepted start.
- Byte lanes (little-endian), with off = address[2:0]:
  - bus_be = (size mask: 0x01/0x03/0x0F/0xFF) << off.
  - bus_wdata = store_data << (8*off).
  - Load result = (bus_rdata >> (8*off)) masked to size, then sign- or zero-extended from the top bit of the size.
- Latency:
  - Start accepted at edge T, bus_req high from T+1.
  - An ack in the same cycle as the first req gives done at T+2.
  - Each cycle of ack delay adds 1.
  - Fault-before-bus cases (codes 1 and 4) give done at T+1.

Decomposition:
- constants.vh gains:
  - MEM_SIZE_BYTE/HALF/WORD/DWORD encodings.
  - FAULT_NONE/MISALIGN/BUSERR/TIMEOUT/ILLEGAL codes.
  - MAU_IDLE/REQ/DONE state encodings.
- One combinational sub-module, mem_lane_align, covers:
  - byte-enable generation,
  - write-data shift,
  - read extract and extension.
- mem_lane_align is reused later by the pipelined MEM stage.

Test Plan:
- Dword load at 0x1000; bus acks at first req with rdata 0x1122334455667788 -> done at T+2, load_data 0x1122334455667788, bus_be 0xFF, fault 0.
- Signed word load at 0x1004, sign_ext=1, rdata 0x80000000_00000000 -> bus_addr 0x1000, bus_be 0xF0, load_data 0xFFFFFFFF80000000; repeat with sign_ext=0 -> 0x0000000080000000.
- Byte store at 0x2003 with store_data 0xAB, ack delayed 3 cycles -> bus_be 0x08, bus_wdata[31:24]=0xAB, busy high 4 cycles, done one cycle after ack.
- Half load at 0x3001 -> done at T+1, fault 1 / fault_code 1, bus_req never asserted, load_data unchanged. Read and write both set -> fault_code 4.
- TIMEOUT=4, no ack -> bus_req high 4 cycles, then done with fault_code 3; bus_err with ack -> fault_code 2.
- Reset asserted mid-REQ -> bus_req, busy and done drop immediately; state IDLE. After reset, a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access stage and its lane aligner.
// Holds access sizes, fault codes, FSM states and small decode helpers.
// Pure declarations; no logic, no latency, no flow control.
package mem_access_unit_pkg;

    // Datapath width of the LEGv8 core.
    localparam int WORD = 64;

    // Access size encodings as presented on the size input.
    localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF  = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD  = 2'b10;
    localparam logic [1:0] MEM_SIZE_DWORD = 2'b11;

    // Fault codes reported alongside done.
    localparam logic [2:0] FAULT_NONE     = 3'd0;
    localparam logic [2:0] FAULT_MISALIGN = 3'd1;
    localparam logic [2:0] FAULT_BUSERR   = 3'd2;
    localparam logic [2:0] FAULT_TIMEOUT  = 3'd3;
    localparam logic [2:0] FAULT_ILLEGAL  = 3'd4;

    // Access FSM states.
    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_t;

    // Byte-lane mask for an access of the given size, before shifting by offset.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            MEM_SIZE_BYTE:  m = 8'h01;
            MEM_SIZE_HALF:  m = 8'h03;
            MEM_SIZE_WORD:  m = 8'h0F;
            default:        m = 8'hFF;
        endcase
        return m;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            MEM_SIZE_BYTE:  bad = 1'b0;
            MEM_SIZE_HALF:  bad = off[0];
            MEM_SIZE_WORD:  bad = |off[1:0];
            default:        bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian byte-lane alignment: byte enables, store shift, load extract/extend.
// Purely combinational, zero latency.
// No flow control; shared by the multicycle access unit and the pipelined MEM stage.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [2:0]      off,
    input  logic            sign_ext,
    input  logic [WORD-1:0] store_data,
    input  logic [WORD-1:0] rdata,
    output logic [7:0]      be,
    output logic [WORD-1:0] wdata,
    output logic [WORD-1:0] load_ext
);

    logic [5:0]      bit_shift;
    logic [WORD-1:0] rd_shifted;

    assign bit_shift = {off, 3'b000};

    // Place the store operand into its lanes and select the matching byte enables.
    always_comb begin
        be    = size_mask(size) << off;
        wdata = store_data << bit_shift;
    end

    // Bring the addressed bytes down to bit 0, then extend from the top bit of the size.
    // For dword there is nothing to extend, so sign_ext has no effect.
    always_comb begin
        rd_shifted = rdata >> bit_shift;
        case (size)
            MEM_SIZE_BYTE:
                load_ext = {{56{sign_ext & rd_shifted[7]}}, rd_shifted[7:0]};
            MEM_SIZE_HALF:
                load_ext = {{48{sign_ext & rd_shifted[15]}}, rd_shifted[15:0]};
            MEM_SIZE_WORD:
                load_ext = {{32{sign_ext & rd_shifted[31]}}, rd_shifted[31:0]};
            default:
                load_ext = rd_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: ALU result as address, one req/ack bus transaction per op.
// Latency: done 2 cycles after accept when acked at once, +1 per ack-delay cycle; 1 cycle on pre-bus faults.
// Backpressure: busy stalls control while in REQ; a silent bus is cut off after TIMEOUT cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] load_data,
    output logic            fault,
    output logic [2:0]      fault_code,
    output logic            bus_req,
    output logic            bus_we,
    output logic [WORD-1:0] bus_addr,
    output logic [WORD-1:0] bus_wdata,
    output logic [7:0]      bus_be,
    input  logic            bus_ack,
    input  logic [WORD-1:0] bus_rdata,
    input  logic            bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mau_state_t state, state_nxt;

    // Op attributes captured on the accept edge; later input changes are ignored.
    logic            op_read;
    logic [1:0]      op_size;
    logic            op_sext;
    logic [2:0]      op_off;
    logic [7:0]      wait_cnt;

    // FSM decisions consumed by the datapath registers.
    logic            accept_bus;
    logic            load_en;
    logic [2:0]      fault_code_nxt;

    // Aligner inputs: live request while idle, captured op once the bus is running.
    logic            in_idle;
    logic [1:0]      al_size;
    logic [2:0]      al_off;
    logic            al_sext;
    logic [7:0]      al_be;
    logic [WORD-1:0] al_wdata;
    logic [WORD-1:0] al_load;

    assign in_idle = (state == MAU_IDLE);
    assign al_size = in_idle ? size        : op_size;
    assign al_off  = in_idle ? address[2:0] : op_off;
    assign al_sext = in_idle ? sign_ext    : op_sext;

    mem_lane_align u_align (
        .size       (al_size),
        .off        (al_off),
        .sign_ext   (al_sext),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_ext   (al_load)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MAU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived handshake outputs.
    always_comb begin
        state_nxt      = state;
        accept_bus     = 1'b0;
        load_en        = 1'b0;
        fault_code_nxt = fault_code;
        busy           = 1'b0;
        bus_req        = 1'b0;
        done           = 1'b0;
        fault          = 1'b0;
        case (state)
            MAU_IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    if (mem_read && mem_write) begin
                        fault_code_nxt = FAULT_ILLEGAL;
                        state_nxt      = MAU_DONE;
                    end else if (is_misaligned(size, address[2:0])) begin
                        fault_code_nxt = FAULT_MISALIGN;
                        state_nxt      = MAU_DONE;
                    end else begin
                        fault_code_nxt = FAULT_NONE;
                        accept_bus     = 1'b1;
                        state_nxt      = MAU_REQ;
                    end
                end
            end
            MAU_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    if (bus_err) begin
                        fault_code_nxt = FAULT_BUSERR;
                    end else begin
                        fault_code_nxt = FAULT_NONE;
                        load_en        = op_read;
                    end
                    state_nxt = MAU_DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    fault_code_nxt = FAULT_TIMEOUT;
                    state_nxt      = MAU_DONE;
                end
            end
            MAU_DONE: begin
                done      = 1'b1;
                fault     = (fault_code != FAULT_NONE);
                state_nxt = MAU_IDLE;
            end
            default: begin
                state_nxt = MAU_IDLE;
            end
        endcase
    end

    // Bus-side request registers, loaded once per accepted op and held through REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            op_read   <= 1'b0;
            op_size   <= MEM_SIZE_BYTE;
            op_sext   <= 1'b0;
            op_off    <= '0;
        end else if (accept_bus) begin
            bus_we    <= mem_write;
            bus_addr  <= {address[WORD-1:3], 3'b000};
            bus_wdata <= al_wdata;
            bus_be    <= al_be;
            op_read   <= mem_read;
            op_size   <= size;
            op_sext   <= sign_ext;
            op_off    <= address[2:0];
        end
    end

    // Ack wait counter: cleared on accept, advances every REQ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (accept_bus) begin
            wait_cnt <= '0;
        end else if (state == MAU_REQ) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Result registers: fault code persists until the next accepted start,
    // load data only changes on an error-free read completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_code <= FAULT_NONE;
            load_data  <= '0;
        end else begin
            fault_code <= fault_code_nxt;
            if (load_en) begin
                load_data <= al_load;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a bus responder,
// with completion results checked by a scoreboard on every done pulse.
// Hand sequences cover reset state, ignored starts, and reset during a transaction.
module tb_mem_access_unit;

    localparam int TMO   = 4;
    localparam int NEVER = 1000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [63:0] address;
    logic [63:0] store_data;
    logic        busy;
    logic        done;
    logic [63:0] load_data;
    logic        fault;
    logic [2:0]  fault_code;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_be;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .fault_code (fault_code),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [63:0] addr;
        logic [63:0] sdata;
        int          dly;
        logic        err;
        logic [63:0] rdata;
        logic [7:0]  e_be;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [63:0] e_load;
        logic [2:0]  e_code;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [2:0]  code;
        logic [63:0] load;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                                input logic [63:0] a, input logic [63:0] sd, input int dl, input logic er,
                                input logic [63:0] rdt, input logic [7:0] be, input logic [63:0] ea,
                                input logic [63:0] ew, input logic [63:0] el, input logic [2:0] ec);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = sz; v.sext = sx; v.addr = a; v.sdata = sd;
        v.dly = dl; v.err = er; v.rdata = rdt; v.e_be = be; v.e_addr = ea;
        v.e_wdata = ew; v.e_load = el; v.e_code = ec;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no completion", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_fault_code"}, 64'(fault_code), 64'(e.code));
                chk({e.name, "_fault"}, 64'(fault), 64'(e.code != 3'd0));
                chk({e.name, "_load_data"}, load_data, e.load);
            end
        end
    end

    // Drive one op from a negedge, act as the bus slave, and check the request side.
    task automatic run_vec(input vec_t v, input string name);
        logic  bus_op;
        int    exp_req;
        int    lat;
        int    reqc;
        int    busyc;
        exp_t  e;
        bus_op  = (v.e_code == 3'd0) || (v.e_code == 3'd2) || (v.e_code == 3'd3);
        exp_req = !bus_op ? 0 : ((v.e_code == 3'd3) ? TMO : v.dly + 1);
        lat     = bus_op ? exp_req + 1 : 1;
        reqc    = 0;
        busyc   = 0;
        start      = 1'b1;
        mem_read   = v.rd;
        mem_write  = v.wr;
        size       = v.size;
        sign_ext   = v.sext;
        address    = v.addr;
        store_data = v.sdata;
        e.cyc  = cyc + lat;
        e.code = v.e_code;
        e.load = v.e_load;
        e.name = name;
        sb.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start      = 1'b0;
                mem_read   = $urandom_range(0, 1) == 1;
                size       = 2'($urandom_range(0, 3));
                sign_ext   = ~v.sext;
                address    = {$urandom, $urandom};
                store_data = {$urandom, $urandom};
                if (bus_op) begin
                    chk({name, "_bus_addr"}, bus_addr, v.e_addr);
                    chk({name, "_bus_be"}, 64'(bus_be), 64'(v.e_be));
                    chk({name, "_bus_we"}, 64'(bus_we), 64'(v.wr));
                    if (v.wr) chk({name, "_bus_wdata"}, bus_wdata, v.e_wdata);
                end
            end
            if (bus_req) reqc++;
            if (busy) busyc++;
            if (k == lat + 1) chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
            bus_ack   = bus_op && (v.dly != NEVER) && (k == v.dly + 1);
            bus_err   = v.err;
            bus_rdata = bus_ack ? v.rdata : {$urandom, $urandom};
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        chk({name, "_req_cycles"}, 64'(reqc), 64'(exp_req));
        chk({name, "_busy_cycles"}, 64'(busyc), 64'(exp_req));
        chk({name, "_completed"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int reqc;
        vec_t fresh;

        vt[0]  = mk(1, 0, 2'd3, 0, 64'h1000, 64'h0, 0, 0, 64'h1122334455667788, 8'hFF, 64'h1000, 64'h0, 64'h1122334455667788, 3'd0);
        vt[1]  = mk(1, 0, 2'd2, 1, 64'h1004, 64'h0, 1, 0, 64'h8000000000000000, 8'hF0, 64'h1000, 64'h0, 64'hFFFFFFFF80000000, 3'd0);
        vt[2]  = mk(1, 0, 2'd2, 0, 64'h1004, 64'h0, 0, 0, 64'h8000000000000000, 8'hF0, 64'h1000, 64'h0, 64'h0000000080000000, 3'd0);
        vt[3]  = mk(0, 1, 2'd0, 0, 64'h2003, 64'hAB, 3, 0, 64'h0, 8'h08, 64'h2000, 64'h00000000AB000000, 64'h0000000080000000, 3'd0);
        vt[4]  = mk(1, 0, 2'd1, 0, 64'h3001, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000000080000000, 3'd1);
        vt[5]  = mk(1, 1, 2'd3, 0, 64'h1000, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000000080000000, 3'd4);
        vt[6]  = mk(1, 0, 2'd0, 1, 64'h6005, 64'h0, 2, 0, 64'h0000850000000000, 8'h20, 64'h6000, 64'h0, 64'hFFFFFFFFFFFFFF85, 3'd0);
        vt[7]  = mk(1, 0, 2'd3, 0, 64'h5008, 64'h0, 0, 1, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'h5008, 64'h0, 64'hFFFFFFFFFFFFFF85, 3'd2);
        vt[8]  = mk(1, 0, 2'd1, 0, 64'h6006, 64'h0, 0, 0, 64'hFFFE000000000000, 8'hC0, 64'h6000, 64'h0, 64'h000000000000FFFE, 3'd0);
        vt[9]  = mk(1, 0, 2'd1, 1, 64'h6002, 64'h0, 1, 0, 64'h000000007FFF0000, 8'h0C, 64'h6000, 64'h0, 64'h0000000000007FFF, 3'd0);
        vt[10] = mk(0, 1, 2'd2, 0, 64'h5000, 64'h11223344, 0, 1, 64'h0, 8'h0F, 64'h5000, 64'h11223344, 64'h0000000000007FFF, 3'd2);
        vt[11] = mk(1, 0, 2'd2, 0, 64'h7002, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000000000007FFF, 3'd1);
        vt[12] = mk(0, 1, 2'd3, 0, 64'h7004, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000000000007FFF, 3'd1);
        vt[13] = mk(0, 1, 2'd3, 0, 64'h8000, 64'h0123456789ABCDEF, 1, 0, 64'h0, 8'hFF, 64'h8000, 64'h0123456789ABCDEF, 64'h0000000000007FFF, 3'd0);
        vt[14] = mk(0, 1, 2'd2, 0, 64'h8004, 64'hCAFEBABE12345678, 0, 0, 64'h0, 8'hF0, 64'h8000, 64'h1234567800000000, 64'h0000000000007FFF, 3'd0);
        vt[15] = mk(1, 0, 2'd3, 0, 64'h4000, 64'h0, NEVER, 0, 64'h0, 8'hFF, 64'h4000, 64'h0, 64'h0000000000007FFF, 3'd3);
        vt[16] = mk(1, 0, 2'd3, 1, 64'h9000, 64'h0, 0, 0, 64'h8000000000000001, 8'hFF, 64'h9000, 64'h0, 64'h8000000000000001, 3'd0);
        vt[17] = mk(1, 0, 2'd0, 0, 64'h9007, 64'h0, 0, 0, 64'hA500000000000000, 8'h80, 64'h9000, 64'h0, 64'h00000000000000A5, 3'd0);

        reset      = 1'b0;
        start      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'd0;
        sign_ext   = 1'b0;
        address    = '0;
        store_data = '0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        bus_err    = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_load_data", load_data, 64'd0);
        chk("rst_fault", {61'd0, fault_code}, 64'd0);
        chk("rst_bus_side", {bus_we, bus_be, bus_addr[54:0]} | bus_wdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Start with neither read nor write, and stray acks while idle, must do nothing.
        start   = 1'b1;
        bus_ack = 1'b1;
        reqc    = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_req || busy) reqc++;
        end
        start   = 1'b0;
        bus_ack = 1'b0;
        chk("idle_nop_activity", 64'(reqc), 64'd0);
        chk("idle_nop_load", load_data, 64'd0);

        for (int i = 0; i < 18; i++) begin
            run_vec(vt[i], $sformatf("v%0d", i));
        end

        // Reset while a load is waiting for its ack.
        start     = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        size      = 2'd3;
        address   = 64'hA000;
        @(negedge clk);
        start = 1'b0;
        chk("midrst_req_up", 64'(bus_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_bus_req", 64'(bus_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_load_data", load_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 64'(bus_req | busy | done), 64'd0);

        fresh = mk(1, 0, 2'd3, 0, 64'hB000, 64'h0, 1, 0, 64'h0F0E0D0C0B0A0908, 8'hFF, 64'hB000, 64'h0, 64'h0F0E0D0C0B0A0908, 3'd0);
        run_vec(fresh, "post_rst");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
